// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encoding, data-width constants and bit-period width for the UART receiver
package uart_rx_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA} rx_state_t;
  localparam int D7 = 7;
  localparam int D8 = 8;
  localparam int KW = 19;
  function automatic logic [KW-1:0] k_clamp(input logic [KW-1:0] k);
    return (k < KW'(2)) ? KW'(2) : k;
  endfunction
endpackage

// File: rtl/rx_bit_timer.sv
// rx_bit_timer: half/full bit-period counter plus sample counter, with tick and last-sample pulses
module rx_bit_timer
  import uart_rx_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          half,
  input  logic [KW-1:0] k,
  input  logic [3:0]    nsamp,
  output logic          tick,
  output logic          last,
  output logic [3:0]    bidx
);
  logic [KW-1:0] cnt;
  logic [KW-1:0] target;
  always_comb begin
    target = half ? (k >> 1) : k;
    tick = run && (cnt == target - KW'(1));
    last = tick && !half && (bidx == nsamp - 4'd1);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      bidx <= '0;
    end else if (!run) begin
      cnt <= '0;
      bidx <= '0;
    end else if (tick) begin
      cnt <= '0;
      bidx <= half ? 4'd0 : bidx + 4'd1;
    end else
      cnt <= cnt + KW'(1);
endmodule

// File: rtl/uart_rx_engine.sv
// uart_rx_engine: UART receiver with 7/8 data bits, optional parity, framing/overrun flags.
// Define RX_SYNC_EN to pass RX through a 2-flop synchronizer (adds 2 clocks of latency).
module uart_rx_engine
  import uart_rx_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          READS0,
  input  logic          RX,
  input  logic          EIGHT,
  input  logic          PEN,
  input  logic          OHEL,
  input  logic [KW-1:0] K,
  output logic [7:0]    UART_RDATA,
  output logic          RXRDY,
  output logic          PERR,
  output logic          FERR,
  output logic          OVF
);
  rx_state_t     state;
  logic          rx, armed, eight_q, pen_q, ohel_q, par_q, stop_q, fin, tick, last, exp_par;
  logic [KW-1:0] k_q;
  logic [7:0]    data;
  logic [3:0]    bidx, nd, nsamp;
`ifdef RX_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk or negedge reset)
    if (!reset) sync <= '0;
    else sync <= {sync[0], RX};
  assign rx = sync[1];
`else
  assign rx = RX;
`endif
  always_comb begin
    nd = eight_q ? 4'(D8) : 4'(D7);
    nsamp = nd + {3'd0, pen_q} + 4'd1;
    exp_par = ohel_q ? ~^data : ^data;
  end
  rx_bit_timer u_timer (
    .clk(clk), .reset(reset), .run(state != IDLE), .half(state == START),
    .k(k_q), .nsamp(nsamp), .tick(tick), .last(last), .bidx(bidx)
  );
  // armed blocks a line held low since reset (or since a low stop) from looking like a start bit
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      armed <= 1'b0;
      eight_q <= 1'b0;
      pen_q <= 1'b0;
      ohel_q <= 1'b0;
      k_q <= '0;
      data <= '0;
      par_q <= 1'b0;
      stop_q <= 1'b0;
      fin <= 1'b0;
    end else begin
      fin <= last;
      if (rx) armed <= 1'b1;
      case (state)
        IDLE: if (armed && !rx) begin
          state <= START;
          armed <= 1'b0;
          eight_q <= EIGHT;
          pen_q <= PEN;
          ohel_q <= OHEL;
          k_q <= k_clamp(K);
          data <= '0;
        end
        START: if (tick) state <= rx ? IDLE : DATA;
        DATA: if (tick) begin
          if (bidx < nd) data[bidx[2:0]] <= rx;
          else if (pen_q && bidx == nd) par_q <= rx;
          if (last) begin
            stop_q <= rx;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      UART_RDATA <= '0;
      RXRDY <= 1'b0;
      PERR <= 1'b0;
      FERR <= 1'b0;
      OVF <= 1'b0;
    end else if (fin) begin
      UART_RDATA <= data;
      RXRDY <= 1'b1;
      PERR <= pen_q & (par_q != exp_par);
      FERR <= ~stop_q;
      OVF <= RXRDY;
    end else if (READS0) begin
      RXRDY <= 1'b0;
      PERR <= 1'b0;
      FERR <= 1'b0;
      OVF <= 1'b0;
    end
endmodule

// File: tb/tb_uart_rx_engine.sv
// tb_uart_rx_engine: directed tests for uart_rx_engine with hand-computed expectations
module tb_uart_rx_engine;
  import uart_rx_pkg::*;
  logic clk = 1'b0, reset = 1'b1, READS0 = 1'b0, RX = 1'b0;
  logic EIGHT = 1'b1, PEN = 1'b0, OHEL = 1'b0;
  logic [KW-1:0] K = 19'd109;
  logic [7:0] UART_RDATA;
  logic RXRDY, PERR, FERR, OVF;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  uart_rx_engine dut (
    .clk(clk), .reset(reset), .READS0(READS0), .RX(RX), .EIGHT(EIGHT), .PEN(PEN),
    .OHEL(OHEL), .K(K), .UART_RDATA(UART_RDATA), .RXRDY(RXRDY), .PERR(PERR),
    .FERR(FERR), .OVF(OVF)
  );
  task automatic send(input logic [7:0] d, input int nd, input bit pen, input bit par,
                      input bit stop, input int k);
    RX = 1'b0;
    repeat (k) @(negedge clk);
    for (int i = 0; i < nd; i++) begin
      RX = d[i];
      repeat (k) @(negedge clk);
    end
    if (pen) begin
      RX = par;
      repeat (k) @(negedge clk);
    end
    RX = stop;
    repeat (k) @(negedge clk);
    RX = 1'b1;
  endtask
  task automatic pulse_read;
    READS0 = 1'b1;
    @(negedge clk);
    READS0 = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_reset;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({UART_RDATA, RXRDY, PERR, FERR, OVF} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 000", {UART_RDATA, RXRDY, PERR, FERR, OVF});
    end
    reset = 1'b1;
    repeat (200) @(negedge clk);
    checks++;
    if (dut.state !== IDLE) begin
      errors++;
      $display("FAIL low_at_release_state: got %0d expected %0d", dut.state, IDLE);
    end
    checks++;
    if (RXRDY !== 1'b0) begin
      errors++;
      $display("FAIL low_at_release_rxrdy: got %b expected 0", RXRDY);
    end
    RX = 1'b1;
    repeat (5) @(negedge clk);
  endtask
  task automatic test_8n1;
    int lat;
    EIGHT = 1'b1; PEN = 1'b0; OHEL = 1'b0; K = 19'd109;
    lat = 0;
    fork
      send(8'h55, 8, 1'b0, 1'b0, 1'b1, 109);
      while (!RXRDY && lat < 2000) begin
        @(negedge clk);
        lat++;
      end
    join
    repeat (4) @(negedge clk);
    checks++;
    if (lat < 1034 || lat > 1040) begin
      errors++;
      $display("FAIL 8n1_latency: got %0d expected about %0d", lat, 54 + 9 * 109 + 2);
    end
    checks++;
    if (UART_RDATA !== 8'h55) begin
      errors++;
      $display("FAIL 8n1_data: got %h expected 55", UART_RDATA);
    end
    checks++;
    if ({RXRDY, PERR, FERR, OVF} !== 4'b1000) begin
      errors++;
      $display("FAIL 8n1_flags: got %b expected 1000", {RXRDY, PERR, FERR, OVF});
    end
    pulse_read();
    checks++;
    if (RXRDY !== 1'b0 || UART_RDATA !== 8'h55) begin
      errors++;
      $display("FAIL 8n1_read: got rxrdy=%b data=%h expected rxrdy=0 data=55", RXRDY, UART_RDATA);
    end
  endtask
  task automatic test_parity;
    EIGHT = 1'b0; PEN = 1'b1; OHEL = 1'b1; K = 19'd16;
    send(8'h41, 7, 1'b1, 1'b1, 1'b1, 16);
    repeat (4) @(negedge clk);
    checks++;
    if (UART_RDATA !== 8'h41 || RXRDY !== 1'b1) begin
      errors++;
      $display("FAIL 7o1_good_data: got %h rxrdy=%b expected 41 rxrdy=1", UART_RDATA, RXRDY);
    end
    checks++;
    if (PERR !== 1'b0) begin
      errors++;
      $display("FAIL 7o1_good_perr: got %b expected 0", PERR);
    end
    pulse_read();
    send(8'h41, 7, 1'b1, 1'b0, 1'b1, 16);
    repeat (4) @(negedge clk);
    checks++;
    if (PERR !== 1'b1 || UART_RDATA !== 8'h41) begin
      errors++;
      $display("FAIL 7o1_bad_perr: got perr=%b data=%h expected perr=1 data=41", PERR, UART_RDATA);
    end
    pulse_read();
    checks++;
    if (PERR !== 1'b0) begin
      errors++;
      $display("FAIL 7o1_perr_clear: got %b expected 0", PERR);
    end
    EIGHT = 1'b1; OHEL = 1'b0;
    send(8'h83, 8, 1'b1, 1'b1, 1'b1, 16);
    repeat (4) @(negedge clk);
    checks++;
    if (UART_RDATA !== 8'h83 || PERR !== 1'b0) begin
      errors++;
      $display("FAIL 8e1_good: got data=%h perr=%b expected data=83 perr=0", UART_RDATA, PERR);
    end
    pulse_read();
  endtask
  task automatic test_ferr;
    EIGHT = 1'b1; PEN = 1'b0; OHEL = 1'b0; K = 19'd16;
    send(8'hA3, 8, 1'b0, 1'b0, 1'b0, 16);
    repeat (4) @(negedge clk);
    checks++;
    if (UART_RDATA !== 8'hA3 || {RXRDY, FERR} !== 2'b11) begin
      errors++;
      $display("FAIL ferr_set: got data=%h rxrdy=%b ferr=%b expected A3 1 1", UART_RDATA, RXRDY, FERR);
    end
    pulse_read();
    checks++;
    if ({RXRDY, FERR} !== 2'b00 || UART_RDATA !== 8'hA3) begin
      errors++;
      $display("FAIL ferr_clear: got rxrdy=%b ferr=%b data=%h expected 0 0 A3", RXRDY, FERR, UART_RDATA);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (RXRDY !== 1'b0) begin
      errors++;
      $display("FAIL ferr_no_spurious: got %b expected 0", RXRDY);
    end
  endtask
  task automatic test_back_to_back;
    EIGHT = 1'b1; PEN = 1'b0; K = 19'd16;
    send(8'h12, 8, 1'b0, 1'b0, 1'b1, 16);
    send(8'h34, 8, 1'b0, 1'b0, 1'b1, 16);
    repeat (4) @(negedge clk);
    checks++;
    if (UART_RDATA !== 8'h34) begin
      errors++;
      $display("FAIL b2b_data: got %h expected 34", UART_RDATA);
    end
    checks++;
    if ({RXRDY, OVF, FERR} !== 3'b110) begin
      errors++;
      $display("FAIL b2b_ovf: got rxrdy,ovf,ferr=%b expected 110", {RXRDY, OVF, FERR});
    end
    pulse_read();
    checks++;
    if ({RXRDY, OVF} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_clear: got %b expected 00", {RXRDY, OVF});
    end
  endtask
  task automatic test_kmin;
    EIGHT = 1'b1; PEN = 1'b0; K = 19'd0;
    send(8'h5A, 8, 1'b0, 1'b0, 1'b1, 2);
    repeat (6) @(negedge clk);
    checks++;
    if (UART_RDATA !== 8'h5A || {RXRDY, FERR} !== 2'b10) begin
      errors++;
      $display("FAIL kmin_frame: got data=%h rxrdy=%b ferr=%b expected 5A 1 0", UART_RDATA, RXRDY, FERR);
    end
    pulse_read();
  endtask
  task automatic test_glitch;
    K = 19'd109;
    RX = 1'b0;
    repeat (20) @(negedge clk);
    RX = 1'b1;
    repeat (150) @(negedge clk);
    checks++;
    if (RXRDY !== 1'b0) begin
      errors++;
      $display("FAIL glitch_rxrdy: got %b expected 0", RXRDY);
    end
    checks++;
    if (dut.state !== IDLE) begin
      errors++;
      $display("FAIL glitch_state: got %0d expected %0d", dut.state, IDLE);
    end
  endtask
  task automatic test_reset_mid;
    K = 19'd16;
    send(8'h99, 8, 1'b0, 1'b0, 1'b1, 16);
    repeat (4) @(negedge clk);
    RX = 1'b0;
    repeat (80) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({UART_RDATA, RXRDY, PERR, FERR, OVF} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h expected 000", {UART_RDATA, RXRDY, PERR, FERR, OVF});
    end
    RX = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    send(8'hC3, 8, 1'b0, 1'b0, 1'b1, 16);
    repeat (4) @(negedge clk);
    checks++;
    if (UART_RDATA !== 8'hC3 || {RXRDY, PERR, FERR, OVF} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_mid_next: got data=%h flags=%b expected C3 1000", UART_RDATA, {RXRDY, PERR, FERR, OVF});
    end
  endtask
  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_ferr();
    test_back_to_back();
    test_kmin();
    test_glitch();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
